// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between instruction fetch and data access
module ram_port_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD_IF = 2'd1;
  localparam logic [1:0] RD_D  = 2'd2;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [1:0]        r_state;
  logic [3:0]        r_starve;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_d_hold;
  logic              w_force_if;
  logic [1:0]        w_next;
  // Grants and RAM drive: data has priority unless fetch has waited out the limit
  always_comb begin
    w_force_if = if_req & (r_starve == LIMIT);
    d_gnt      = d_req & ~w_force_if;
    if_gnt     = if_req & ~d_gnt;
    mem_en     = if_gnt | d_gnt;
    mem_we     = d_gnt & d_we;
    mem_addr   = if_gnt ? if_addr : d_addr;
    mem_wdata  = d_wdata;
    mem_be     = mem_we ? d_be : 4'b0000;
    w_next     = if_gnt ? RD_IF : (d_gnt & ~d_we) ? RD_D : IDLE;
  end
  // Responses: RAM data passes through in the return cycle, hold register afterwards
  always_comb begin
    if_rvalid = r_state == RD_IF;
    d_rvalid  = r_state == RD_D;
    if_rdata  = if_rvalid ? mem_rdata : r_if_hold;
    d_rdata   = d_rvalid ? mem_rdata : r_d_hold;
  end
  // Read-owner tracking and consecutive data-grant counter while fetch waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_next;
      r_starve <= (if_gnt | ~if_req) ? 4'd0 : (d_gnt & (r_starve != LIMIT)) ? r_starve + 4'd1 : r_starve;
    end
  end
  // Capture returned read data for the owner so it stays visible after rvalid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      if (r_state == RD_IF) r_if_hold <= mem_rdata;
      if (r_state == RD_D) r_d_hold <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed self-checking bench with a behavioural RAM
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ram [0:255];
  int checks = 0;
  int errors = 0;
  logic prev_if;

  ram_port_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [29:0] ia, input logic dr, input logic dw,
                       input logic [29:0] da, input logic [31:0] dwd, input logic [3:0] be);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = be;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h0D] = 32'h00500093;
    ram[8'h40] = 32'h11223344;
    ram[8'h10] = 32'hAAAA0010;
    ram[8'h20] = 32'hBBBB0020;
    #2;
    chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    step;
    rst = 1'b0;

    // lone fetch
    step;
    drive(1'b1, 30'h0D, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("lf_if_gnt", 64'(if_gnt), 64'd1);
    chk("lf_d_gnt", 64'(d_gnt), 64'd0);
    chk("lf_mem_en", 64'(mem_en), 64'd1);
    chk("lf_mem_we", 64'(mem_we), 64'd0);
    chk("lf_mem_addr", 64'(mem_addr), 64'h0D);
    chk("lf_mem_be", 64'(mem_be), 64'd0);
    step;
    drive(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("lf_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("lf_if_rdata", 64'(if_rdata), 64'h00500093);
    chk("lf_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("idle_mem_en", 64'(mem_en), 64'd0);
    step;
    chk("lf_if_rvalid_drop", 64'(if_rvalid), 64'd0);
    chk("lf_if_rdata_hold", 64'(if_rdata), 64'h00500093);

    // store then load same address
    drive(1'b0, 30'h0, 1'b1, 1'b1, 30'h40, 32'hDEADBEEF, 4'b0011);
    #2;
    chk("st_d_gnt", 64'(d_gnt), 64'd1);
    chk("st_mem_we", 64'(mem_we), 64'd1);
    chk("st_mem_be", 64'(mem_be), 64'b0011);
    chk("st_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("st_mem_addr", 64'(mem_addr), 64'h40);
    step;
    drive(1'b0, 30'h0, 1'b1, 1'b0, 30'h40, 32'h0, 4'b1111);
    #2;
    chk("ld_d_gnt", 64'(d_gnt), 64'd1);
    chk("ld_mem_be", 64'(mem_be), 64'd0);
    chk("st_no_rvalid", 64'(d_rvalid), 64'd0);
    step;
    drive(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("ld_d_rvalid", 64'(d_rvalid), 64'd1);
    chk("ld_d_rdata", 64'(d_rdata), 64'h1122BEEF);
    chk("ld_if_rvalid", 64'(if_rvalid), 64'd0);

    // contention with starvation guard: D,D,D,D,IF repeating
    prev_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      drive(1'b1, 30'h10, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
      #2;
      chk($sformatf("ct_if_gnt_%0d", i), 64'(if_gnt), 64'(i % 5 == 4));
      chk($sformatf("ct_d_gnt_%0d", i), 64'(d_gnt), 64'(i % 5 != 4));
      if (i > 0) begin
        chk($sformatf("ct_if_rvalid_%0d", i), 64'(if_rvalid), 64'(prev_if));
        chk($sformatf("ct_d_rvalid_%0d", i), 64'(d_rvalid), 64'(!prev_if));
        if (prev_if) chk($sformatf("ct_if_rdata_%0d", i), 64'(if_rdata), 64'hAAAA0010);
        else chk($sformatf("ct_d_rdata_%0d", i), 64'(d_rdata), 64'hBBBB0020);
      end
      prev_if = (i % 5 == 4);
    end
    step;
    drive(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("ct_last_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("ct_last_if_rdata", 64'(if_rdata), 64'hAAAA0010);
    chk("ct_d_rdata_hold", 64'(d_rdata), 64'hBBBB0020);

    // back-to-back reads IF, D, IF
    step;
    drive(1'b1, 30'h0D, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("bb_if_gnt0", 64'(if_gnt), 64'd1);
    step;
    drive(1'b0, 30'h0, 1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
    #2;
    chk("bb_d_gnt1", 64'(d_gnt), 64'd1);
    chk("bb_if_rvalid1", 64'(if_rvalid), 64'd1);
    chk("bb_if_rdata1", 64'(if_rdata), 64'h00500093);
    step;
    drive(1'b1, 30'h10, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("bb_if_gnt2", 64'(if_gnt), 64'd1);
    chk("bb_d_rvalid2", 64'(d_rvalid), 64'd1);
    chk("bb_d_rdata2", 64'(d_rdata), 64'h1122BEEF);
    chk("bb_if_rvalid2", 64'(if_rvalid), 64'd0);
    step;
    drive(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("bb_if_rvalid3", 64'(if_rvalid), 64'd1);
    chk("bb_if_rdata3", 64'(if_rdata), 64'hAAAA0010);
    chk("bb_d_rvalid3", 64'(d_rvalid), 64'd0);

    // async reset while a fetch read is granted
    step;
    drive(1'b1, 30'h0D, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("ar_if_gnt", 64'(if_gnt), 64'd1);
    rst = 1'b1;
    #1;
    chk("ar_if_rdata_async", 64'(if_rdata), 64'd0);
    chk("ar_d_rdata_async", 64'(d_rdata), 64'd0);
    chk("ar_if_gnt_in_rst", 64'(if_gnt), 64'd1);
    step;
    chk("ar_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("ar_if_rdata", 64'(if_rdata), 64'd0);
    drive(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    rst = 1'b0;
    step;
    drive(1'b1, 30'h0D, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("ar_lf_if_gnt", 64'(if_gnt), 64'd1);
    step;
    drive(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("ar_lf_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("ar_lf_if_rdata", 64'(if_rdata), 64'h00500093);

    // async reset clears the starvation counter and drops an in-flight load
    for (int i = 0; i < 4; i++) begin
      step;
      drive(1'b1, 30'h10, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
      #2;
      chk($sformatf("sr_pre_d_gnt_%0d", i), 64'(d_gnt), 64'd1);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    #2;
    chk("sr_d_rvalid_dropped", 64'(d_rvalid), 64'd0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        step;
        #2;
      end
      chk($sformatf("sr_d_gnt_%0d", j), 64'(d_gnt), 64'(j < 4));
      chk($sformatf("sr_if_gnt_%0d", j), 64'(if_gnt), 64'(j == 4));
    end
    step;
    drive(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #2;
    chk("sr_final_if_rvalid", 64'(if_rvalid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port, word-addressed RAM between the instruction-fetch requester and the load/store (mem stage) requester.
- Data accesses have priority. A starvation guard forces a fetch grant after STARVE_LIMIT consecutive data grants while fetch is waiting.
- Reads return one cycle after grant. The arbiter tracks which requester owns the in-flight read and routes the returned data to it.

Parameters:
- ADDR_W, 30, word address width (byte address bits [31:2])
- DATA_W, 32, data word width
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_be  in  4  store byte enables; ignored for loads
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid; loads only (registered)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  RAM write
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_be  out  4  RAM byte enables
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read with mem_en=1, mem_we=0

Behaviour:
- Grant rule, combinational and evaluated every cycle:
  - force_if = if_req & (starve_cnt == STARVE_LIMIT).
  - d_gnt = d_req & ~force_if.
  - if_gnt = if_req & ~d_gnt.
  - At most one grant per cycle.
- RAM drive:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr = if_addr when if_gnt, otherwise d_addr.
  - mem_wdata = d_wdata.
  - mem_be = d_be when mem_we, otherwise 4'b0000.
- starve_cnt (4 bits) updates on the rising edge:
  - cleared if if_gnt or ~if_req;
  - otherwise incremented if d_gnt, saturating at STARVE_LIMIT;
  - otherwise held.
- Read-owner state machine (registered) records who owns the RAM read in flight:
  - States: IDLE, RD_IF, RD_D.
  - Next state is RD_IF if if_gnt; RD_D if d_gnt & ~d_we; otherwise IDLE.
  - The state is re-evaluated every cycle, so back-to-back reads are allowed with no bubble.
- Response outputs (registered):
  - if_rvalid = (state == RD_IF).
  - d_rvalid = (state == RD_D).
  - if_rdata = mem_rdata when state == RD_IF; d_rdata = mem_rdata when state == RD_D.
  - Otherwise each rdata holds its last value.
- Latency:
  - Read: grant in cycle N, rvalid/rdata in cycle N+1. The RAM data passes through combinationally in cycle N+1 and is captured into a hold register for later cycles.
  - Store: completes at grant and produces no response.
- Ordering: a store granted in cycle N is visible to any read granted in cycle N+1 or later; the RAM is write-before-read across cycles.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: data wins and fetch waits; if_gnt=0 and the fetch must hold its request.
- Simultaneous requests at the limit: fetch wins, d_gnt=0, counter clears.
- No requests: mem_en=0, mem_be=0, state goes to IDLE.
- Reset (async, any time), all values at reset:
  - state = IDLE, starve_cnt = 0.
  - if_rvalid = 0, d_rvalid = 0, if_rdata = 0, d_rdata = 0.
  - A read in flight when reset asserts is dropped and produces no rvalid.
  - Grants stay combinational and follow the request inputs with starve_cnt = 0.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x0D, RAM[0x0D]=0x00500093 -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0x00500093; d_rvalid=0.
- Store then load same address: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011; next cycle load 0x40 (RAM was 0x11223344) -> mem_be=0011 on store; d_rvalid one cycle after the load grant with d_rdata=0x1122BEEF; no rvalid for the store.
- Contention with starvation guard: if_req and d_req held high for 10 cycles (d_we=0), STARVE_LIMIT=4 -> grant pattern D,D,D,D,IF,D,D,D,D,IF; each rvalid goes to the matching owner one cycle later.
- Back-to-back reads IF, D, IF on consecutive cycles -> responses if_rvalid, d_rvalid, if_rvalid on consecutive cycles with the correct data per owner and no bubbles.
- Async reset mid-read: grant a fetch read in cycle N, assert rst during cycle N before the edge -> if_rvalid stays 0, if_rdata=0, starve_cnt=0; the first request after rst deasserts behaves as the lone-fetch case.
